// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and helpers for the multiply/divide unit
package muldiv_pkg;

  localparam int XLEN   = 32;
  localparam int ITER_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_REM   = 3'd5;
  localparam logic [2:0] OP_REMU  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    WB
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Only these ops work on magnitudes; everything else uses the raw operands.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - issue and write-back signals between pipeline control and the multiply/divide unit
interface muldiv_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  start;
  logic [2:0]            op;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [WIDTH-1:0]      wb_data;

  modport master (
    output start, op, operand_a, operand_b, dest_reg, kill,
    input  busy, done, wb_en, wb_reg, wb_data
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_reg, kill,
    output busy, done, wb_en, wb_reg, wb_data
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide with fixed 34-cycle latency
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = XLEN,
  parameter int REG_ADDR_W = 5
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic                  sign_a;
  logic                  sign_b;
  logic                  b_zero;
  logic [2*WIDTH-1:0]    acc;
  logic [WIDTH-1:0]      mreg;
  logic [REG_ADDR_W-1:0] wb_reg_q;
  logic [WIDTH-1:0]      wb_data_q;

  logic                  accept;
  logic                  div_q;
  logic                  in_sa;
  logic                  in_sb;
  logic [WIDTH-1:0]      mag_a;
  logic [WIDTH-1:0]      mag_b;
  logic [WIDTH:0]        add_x;
  logic [WIDTH:0]        add_y;
  logic                  add_sub;
  logic [WIDTH+1:0]      add_res;
  logic [2*WIDTH-1:0]    acc_step;
  logic [WIDTH-1:0]      quo;
  logic [WIDTH-1:0]      rem;
  logic [WIDTH-1:0]      fix_result;

  assign accept = (state == IDLE) && bus.start && !bus.kill;
  assign div_q  = is_div_op(op_q);
  assign in_sa  = is_signed_op(bus.op) && bus.operand_a[WIDTH-1];
  assign in_sb  = is_signed_op(bus.op) && bus.operand_b[WIDTH-1];
  assign mag_a  = in_sa ? -bus.operand_a : bus.operand_a;
  assign mag_b  = in_sb ? -bus.operand_b : bus.operand_b;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (bus.kill) state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX:  state_nxt = bus.kill ? IDLE : WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One adder serves both loops: add multiplicand to the upper half, or trial-subtract the divisor.
  always_comb begin
    add_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = {1'b0, mreg};
    add_sub = 1'b0;
    if (div_q) begin
      add_x   = acc[2*WIDTH-1:WIDTH-1];
      add_sub = 1'b1;
    end
  end

  assign add_res = {1'b0, add_x} + {1'b0, add_sub ? ~add_y : add_y} + {{(WIDTH+1){1'b0}}, add_sub};

  // Divide: carry out of the trial subtract means the shifted remainder covered the divisor.
  always_comb begin
    acc_step = acc;
    if (div_q) begin
      if (add_res[WIDTH+1]) acc_step = {add_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {add_res[WIDTH:0], acc[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  assign quo = acc[WIDTH-1:0];
  assign rem = acc[2*WIDTH-1:WIDTH];

  // High word of a negated product: invert, and carry in only when the low word is zero.
  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL:   fix_result = quo;
      OP_MULH:  fix_result = (sign_a ^ sign_b) ? (~rem + WIDTH'(quo == '0)) : rem;
      OP_MULHU: fix_result = rem;
      OP_DIV, OP_DIVU: begin
        if (b_zero)               fix_result = '1;
        else if (sign_a ^ sign_b) fix_result = -quo;
        else                      fix_result = quo;
      end
      OP_REM, OP_REMU: fix_result = sign_a ? -rem : rem;
      default:  fix_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_MUL;
      dest_q    <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      acc       <= '0;
      mreg      <= '0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.op;
            dest_q <= bus.dest_reg;
            sign_a <= in_sa;
            sign_b <= in_sb;
            b_zero <= (bus.operand_b == '0);
            cnt    <= '0;
            if (is_div_op(bus.op)) begin
              mreg <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              mreg <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          acc <= acc_step;
        end
        FIX: begin
          if (!bus.kill) begin
            wb_reg_q  <= dest_q;
            wb_data_q <= fix_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == WB);
  assign bus.wb_en   = (state == WB) && (dest_q != '0);
  assign bus.wb_reg  = wb_reg_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench: directed vector table, kill/reset sequences, random ops vs arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  muldiv_unit #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_data = '0;
  logic [4:0]  last_reg = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0]     p;
    int              qs;
    int              rs;
    case (op)
      OP_MUL:   begin p = ua * ub; return p[31:0]; end
      OP_MULH:  begin p = sa * sb; return p[63:32]; end
      OP_MULHU: begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        qs = $signed(a) / $signed(b);
        return qs;
      end
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        rs = $signed(a) % $signed(b);
        return rs;
      end
      OP_REMU:  return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg  = dest;
  endtask

  // Called at a negedge with the unit idle; returns at the first idle negedge after write-back.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic hold_start);
    logic [31:0] exp = model(op, a, b);
    int          done_cyc = 0;
    int          busy_cnt = 0;
    drive_start(op, a, b, dest);
    @(negedge clk);
    bus.start     = hold_start;
    bus.op        = 3'($urandom_range(0, 7));
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.dest_reg  = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = c;
        bus.start = 1'b0;
        check({name, ".data"}, 64'(bus.wb_data), 64'(exp));
        check({name, ".wb_en"}, 64'(bus.wb_en), 64'(dest != 0));
        check({name, ".wb_reg"}, 64'(bus.wb_reg), 64'(dest));
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, ".latency"}, 64'(done_cyc), 64'd34);
    check({name, ".busy_cycles"}, 64'(busy_cnt), 64'd34);
    @(negedge clk);
    check({name, ".idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    last_data = exp;
    last_reg  = dest;
  endtask

  vec_t vecs[14];
  logic saw_done;

  initial begin
    vecs[0]  = '{OP_MUL,   32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULH,  32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    vecs[2]  = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[3]  = '{OP_MUL,   32'd1234,       32'd5678,      5'd0,  32'd7006652};
    vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFD};
    vecs[5]  = '{OP_REM,   32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIVU,  32'd100,        32'd7,         5'd6,  32'd14};
    vecs[7]  = '{OP_REMU,  32'd100,        32'd7,         5'd7,  32'd2};
    vecs[8]  = '{OP_DIVU,  32'd100,        32'd0,         5'd8,  32'hFFFF_FFFF};
    vecs[9]  = '{OP_REMU,  32'd100,        32'd0,         5'd9,  32'd100};
    vecs[10] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
    vecs[11] = '{OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0};
    vecs[12] = '{OP_RSVD,  32'd55,         32'd66,        5'd12, 32'h0};
    vecs[13] = '{OP_MULH,  32'hFFFF_FFFF, 32'd3,         5'd13, 32'hFFFF_FFFF};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset.outputs", {bus.busy, bus.done, bus.wb_en, bus.wb_reg, bus.wb_data}, 64'd0);

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, (i % 4) == 1);
    for (int i = 0; i < 14; i++)
      check($sformatf("vec%0d.table", i), 64'(model(vecs[i].op, vecs[i].a, vecs[i].b)), 64'(vecs[i].exp));

    // kill in IDLE suppresses the start
    drive_start(OP_DIVU, 32'd9, 32'd3, 5'd1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    check("kill_idle.busy", 64'(bus.busy), 64'd0);

    // kill at cycle 10 of CALC
    drive_start(OP_DIVU, 32'd1000, 32'd3, 5'd20);
    saw_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      saw_done |= bus.done | bus.wb_en;
      @(negedge clk);
    end
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_calc.no_done", 64'(saw_done | bus.done | bus.wb_en), 64'd0);
    check("kill_calc.busy", 64'(bus.busy), 64'd0);
    check("kill_calc.wb_data_held", 64'(bus.wb_data), 64'(last_data));
    run_op("after_kill", OP_MUL, 32'd11, 32'd13, 5'd21, 1'b0);

    // kill in FIX (cycle 33)
    drive_start(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd22);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (32) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_fix.outputs", {bus.busy, bus.done, bus.wb_en}, 64'd0);
    check("kill_fix.wb_data_held", 64'(bus.wb_data), 64'(last_data));
    check("kill_fix.wb_reg_held", 64'(bus.wb_reg), 64'(last_reg));

    // kill in WB is ignored
    drive_start(OP_REMU, 32'd77, 32'd10, 5'd23);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (33) @(negedge clk);
    bus.kill = 1'b1;
    check("kill_wb.done", {bus.done, bus.wb_en}, 64'd3);
    check("kill_wb.data", 64'(bus.wb_data), 64'd7);
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_wb.idle", 64'(bus.busy), 64'd0);

    // synchronous reset at cycle 20
    drive_start(OP_MUL, 32'd99, 32'd99, 5'd24);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_mid.outputs", {bus.busy, bus.done, bus.wb_en, bus.wb_reg, bus.wb_data}, 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      saw_done |= bus.busy | bus.done;
      @(negedge clk);
    end
    check("reset_mid.no_wb", 64'(saw_done), 64'd0);
    run_op("after_reset", OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd25, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), ra, rb, 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit; consumes the two register-file read operands and produces one register-file write-back.
- Sits between operand read (read_data_1/read_data_2) and the register-file write port.
- Pipeline control stalls issue while busy is high.
- Fixed latency of 34 cycles: radix-2 shift-add multiply, restoring divide, operating on magnitudes with a final sign fix.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- REG_ADDR_W, 5, width of the destination register index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  issue request; sampled only when busy=0.
- op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved.
- operand_a  in  WIDTH  rs value (multiplicand/dividend).
- operand_b  in  WIDTH  rt value (multiplier/divisor).
- dest_reg  in  REG_ADDR_W  destination register index.
- kill  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  high from accept until write-back completes.
- done  out  1  one-cycle completion pulse.
- wb_en  out  1  register-file write enable.
- wb_reg  out  REG_ADDR_W  register-file write index.
- wb_data  out  WIDTH  register-file write data.

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low.
- Reset, including mid-operation: state returns to IDLE; busy, done, wb_en, wb_reg, wb_data all 0; no write-back is produced.
- States and transitions:
  - IDLE -> CALC on start && !kill.
  - CALC: 32 cycles, counted by a 5-bit counter, then -> FIX.
  - FIX: 1 cycle -> WB.
  - WB: 1 cycle -> IDLE.
- Accept edge: latch op, dest_reg, operand signs, and |a|, |b|. Absolute values are taken only for MULH, DIV and REM; MUL uses the raw operands.
- Latency: accept edge E0; CALC covers cycles 1–32, FIX cycle 33, WB cycle 34.
- busy is high in CALC, FIX and WB; start is ignored while busy. Earliest next accept is the first IDLE cycle.
- WB cycle outputs: done=1 and wb_data valid. wb_en=1 only if dest_reg!=0; wb_reg=dest_reg.
- Outside WB: done and wb_en are 0; wb_reg and wb_data hold their last values.
- Multiply: 64-bit magnitude product. FIX negates the product when signs differ (MULH only). MUL returns the low word; MULH/MULHU return the high word.
- Divide (restoring): 32 quotient bits, one per CALC cycle. FIX applies signs:
  - Quotient sign = sign_a ^ sign_b.
  - Remainder sign = sign_a (truncating division).
- Divide by zero: quotient = all ones, remainder = operand_a unmodified. Same 34-cycle latency.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- op=7: result 0, same latency, wb_en still follows the dest_reg rule.
- kill:
  - In CALC or FIX: return to IDLE on the next edge; no done, no wb_en.
  - In WB: ignored; the write completes.
  - In IDLE: start is ignored that cycle.
- Operand inputs may change freely after the accept edge.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants (OP_MUL … OP_REMU, OP_RSVD).
  - state enum (IDLE, CALC, FIX, WB).
  - ITER_W = $clog2(WIDTH).
- No sub-module. Single iterative datapath: one 2*WIDTH accumulator/remainder register, one WIDTH shift register, and a shared WIDTH+1 adder/subtractor.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3), dest=5 -> busy high 34 cycles; in cycle 34: done=1, wb_en=1, wb_reg=5, wb_data=0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MUL with dest=0 -> done=1, wb_en=0.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Start accepted, kill at cycle 10 -> busy low from cycle 11, no done or wb_en. New start in cycle 11 is accepted and completes normally. A start asserted while busy is ignored.
- rst_n low at cycle 20 of an operation -> next cycle all outputs 0 and state IDLE, no write-back. An op issued after reset completes in 34 cycles.
